// File: rtl/inv_cipher_round_ctrl_pkg.sv
// rtl/inv_cipher_round_ctrl_pkg.sv - AES-256 decryption constants, FSM states and GF(2^8) helpers
package inv_cipher_round_ctrl_pkg;

  localparam int AES256_NR = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant, enough for the 9/b/d/e inverse mix-columns coefficients.
  function automatic logic [7:0] gf_mul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2, a4, a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul_k(a0, 4'he) ^ gf_mul_k(a1, 4'hb) ^ gf_mul_k(a2, 4'hd) ^ gf_mul_k(a3, 4'h9),
            gf_mul_k(a0, 4'h9) ^ gf_mul_k(a1, 4'he) ^ gf_mul_k(a2, 4'hb) ^ gf_mul_k(a3, 4'hd),
            gf_mul_k(a0, 4'hd) ^ gf_mul_k(a1, 4'h9) ^ gf_mul_k(a2, 4'he) ^ gf_mul_k(a3, 4'hb),
            gf_mul_k(a0, 4'hb) ^ gf_mul_k(a1, 4'hd) ^ gf_mul_k(a2, 4'h9) ^ gf_mul_k(a3, 4'he)};
  endfunction

endpackage

// File: rtl/inv_cipher_round_ctrl_if.sv
// rtl/inv_cipher_round_ctrl_if.sv - ciphertext in, round-key fetch and plaintext out channels
interface inv_cipher_round_ctrl_if #(
  parameter int RK_IDX_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in_data;
  logic                rk_req;
  logic [RK_IDX_W-1:0] rk_idx;
  logic                rk_valid;
  logic [127:0]        rk_data;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_data;

  modport master (
    output in_valid, in_data, rk_valid, rk_data, out_ready,
    input  in_ready, rk_req, rk_idx, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, rk_valid, rk_data, out_ready,
    output in_ready, rk_req, rk_idx, out_valid, out_data
  );
endinterface

// File: rtl/inv_round_datapath.sv
// rtl/inv_round_datapath.sv - combinational inverse AES round: shift-rows, sub-bytes, add-key, mix-columns
module inv_round_datapath
  import inv_cipher_round_ctrl_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         is_first,
  input  logic         is_last,
  output logic [127:0] result
);
  logic [127:0] shifted;
  logic [127:0] keyed;
  logic [127:0] mixed;

  // Byte 4*c+r is row r of column c; row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4 * c + r;
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      assign shifted[127-8*DST -: 8] = st[127-8*SRC -: 8];
      assign keyed[127-8*DST -: 8]   = INV_SBOX[shifted[127-8*DST -: 8]] ^ rk[127-8*DST -: 8];
    end
    assign mixed[127-32*c -: 32] = inv_mix_col(keyed[127-32*c -: 32]);
  end

  assign result = is_first ? (st ^ rk) : (is_last ? keyed : mixed);
endmodule

// File: rtl/inv_cipher_round_ctrl.sv
// rtl/inv_cipher_round_ctrl.sv - iterative AES-256 decryption round controller
module inv_cipher_round_ctrl
  import inv_cipher_round_ctrl_pkg::*;
#(
  parameter int NR       = AES256_NR,
  parameter int RK_IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  inv_cipher_round_ctrl_if.slave bus,
  output logic                   busy
);
  localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

  state_e              state_q, state_d;
  logic [RK_IDX_W-1:0] round_q, round_d;
  logic [127:0]        st_q, st_d;
  logic [127:0]        dp_out;

  inv_round_datapath u_dp (
    .st       (st_q),
    .rk       (bus.rk_data),
    .is_first (round_q == NR_IDX),
    .is_last  (round_q == '0),
    .result   (dp_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= NR_IDX;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
    end
  end

  // Outside KEY rk_idx parks at NR, so it only moves on a cycle that consumed a key.
  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    st_d          = st_q;
    bus.in_ready  = 1'b0;
    bus.rk_req    = 1'b0;
    bus.rk_idx    = NR_IDX;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          st_d    = bus.in_data;
          round_d = NR_IDX;
          state_d = KEY;
        end
      end
      KEY: begin
        bus.rk_req = 1'b1;
        bus.rk_idx = round_q;
        if (bus.rk_valid) begin
          st_d = dp_out;
          if (round_q == '0) begin
            state_d = DONE;
          end else begin
            round_d = round_q - 1'b1;
          end
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_data = st_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_inv_cipher_round_ctrl.sv
// tb/tb_inv_cipher_round_ctrl.sv - directed and randomized checks against a textbook AES-256 decryption model
module tb_inv_cipher_round_ctrl;
  localparam int NR = 14;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  inv_cipher_round_ctrl_if #(.RK_IDX_W(4)) bus ();

  inv_cipher_round_ctrl #(.NR(NR), .RK_IDX_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ov_cycles = 0;
  bit rk_rand = 1'b0;
  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [31:0]  w       [60];
  logic [127:0] rkey    [15];
  int           acc_q[$];
  logic [127:0] out_q[$];
  int           rk_log[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x] = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [7:0]  rcon = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k <= NR; k++) rkey[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] imc [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0] tmp;
    logic [127:0] res;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) s[r][c] = ct[127-8*(4*c+r) -: 8];
    for (int rnd = NR; rnd >= 0; rnd--) begin
      if (rnd < NR) begin
        for (int r = 0; r < 4; r++)
          repeat (r) begin
            tmp = s[r][3]; s[r][3] = s[r][2]; s[r][2] = s[r][1]; s[r][1] = s[r][0]; s[r][0] = tmp;
          end
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = isbox_t[s[r][c]];
      end
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ rkey[rnd][127-8*(4*c+r) -: 8];
      if (rnd > 0 && rnd < NR) begin
        for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) begin
          t[r][c] = 8'h00;
          for (int j = 0; j < 4; j++) t[r][c] = t[r][c] ^ gmul(imc[(j - r + 4) % 4], s[j][c]);
        end
        s = t;
      end
    end
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // One clock: log handshakes seen at the edge, check rk_idx holding, then play the key store.
  task automatic tick();
    logic hs_in  = bus.in_valid & bus.in_ready & ~rst;
    logic hs_out = bus.out_valid & bus.out_ready & ~rst;
    logic rkv_s  = bus.rk_valid;
    logic req_s  = bus.rk_req;
    logic rst_s  = rst;
    logic [3:0]   idx_s  = bus.rk_idx;
    logic [127:0] data_s = bus.out_data;
    @(posedge clk);
    #1;
    cyc++;
    if (hs_in) acc_q.push_back(cyc);
    if (hs_out) out_q.push_back(data_s);
    if (req_s && rkv_s && !rst_s) rk_log.push_back(int'(idx_s));
    if (!rst_s && !rkv_s) check("rk_idx_hold", 128'(bus.rk_idx), 128'(idx_s));
    if (bus.out_valid) ov_cycles++;
    bus.rk_valid = rk_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.rk_data  = (bus.rk_idx <= 4'd14) ? rkey[bus.rk_idx] : '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 128'(bus.in_ready), 128'd1);
    check({tag, "_rk_req"}, 128'(bus.rk_req), 128'd0);
    check({tag, "_rk_idx"}, 128'(bus.rk_idx), 128'(NR));
    check({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    check({tag, "_out_data"}, bus.out_data, 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
  endtask

  task automatic send(input logic [127:0] d);
    int n0 = acc_q.size();
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (acc_q.size() == n0 && n < 100) begin tick(); n++; end
    bus.in_valid = 1'b0;
    check("accept", 128'(acc_q.size() - n0), 128'd1);
  endtask

  task automatic wait_ov(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin tick(); n++; end
    check("out_valid_timeout", 128'(bus.out_valid), 128'd1);
  endtask

  initial begin
    logic [127:0] pt, ct1, ct2;
    int a, n, n0, oq0, ov0;

    init_sbox();
    expand_key(C3_KEY);
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus.rk_valid = 1'b0; bus.rk_data = '0;
    rst = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;

    // FIPS-197 C.3 with keys always available: latency and plaintext.
    send(C3_CT);
    a = acc_q[$];
    wait_ov(50);
    check("c3_latency", 128'(cyc + 1 - a), 128'(NR + 2));
    check("c3_busy", 128'(busy), 128'd1);
    check("c3_pt_const", bus.out_data, C3_PT);
    check("c3_pt_model", bus.out_data, ref_decrypt(C3_CT));
    tick();
    check("c3_out_q", out_q[$], C3_PT);
    check("c3_idle", 128'(bus.in_ready), 128'd1);

    // Random key-store stalls: same plaintext, key indices 14..0 in order.
    rk_rand = 1'b1;
    rk_log.delete();
    send(C3_CT);
    wait_ov(400);
    check("stall_pt", bus.out_data, C3_PT);
    tick();
    rk_rand = 1'b0;
    check("rk_seq_len", 128'(rk_log.size()), 128'd15);
    for (int i = 0; i < 15; i++)
      check("rk_seq", 128'(i < rk_log.size() ? rk_log[i] : -1), 128'(NR - i));

    // Output back-pressure with stray in_valid pulses.
    bus.out_ready = 1'b0;
    send(C3_CT);
    n0 = acc_q.size();
    n = 0;
    while (!bus.out_valid && n < 50) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    check("bp_out_valid", 128'(bus.out_valid), 128'd1);
    pt = bus.out_data;
    check("bp_pt", pt, C3_PT);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      tick();
      check("bp_hold_valid", 128'(bus.out_valid), 128'd1);
      check("bp_hold_data", bus.out_data, pt);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
    end
    bus.in_valid = 1'b0;
    check("bp_no_accept", 128'(acc_q.size()), 128'(n0));
    bus.out_ready = 1'b1;
    tick();
    check("bp_released", 128'(bus.out_valid), 128'd0);
    check("bp_out_q", out_q[$], C3_PT);

    // Reset in the middle of round 7 abandons the block.
    send(C3_CT);
    n = 0;
    while (bus.rk_idx != 4'd7 && n < 50) begin tick(); n++; end
    check("abort_round7", 128'(bus.rk_idx), 128'd7);
    rst = 1'b1;
    tick();
    check_reset("abort");
    rst = 1'b0;
    ov0 = ov_cycles;
    oq0 = out_q.size();
    repeat (20) tick();
    check("abort_no_ov", 128'(ov_cycles - ov0), 128'd0);
    check("abort_no_out", 128'(out_q.size() - oq0), 128'd0);
    send(C3_CT);
    wait_ov(50);
    check("abort_fresh_pt", bus.out_data, C3_PT);
    tick();

    // Back-to-back random blocks with in_valid held high.
    ct1 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = {$urandom, $urandom, $urandom, $urandom};
    n0 = acc_q.size();
    oq0 = out_q.size();
    bus.in_valid = 1'b1;
    bus.in_data = ct1;
    n = 0;
    while (acc_q.size() == n0 && n < 50) begin tick(); n++; end
    bus.in_data = ct2;
    while (acc_q.size() < n0 + 2 && n < 100) begin tick(); n++; end
    bus.in_valid = 1'b0;
    check("b2b_accepts", 128'(acc_q.size() - n0), 128'd2);
    check("b2b_period", 128'(acc_q[$] - acc_q[$-1]), 128'(NR + 3));
    n = 0;
    while (out_q.size() < oq0 + 2 && n < 60) begin tick(); n++; end
    check("b2b_outs", 128'(out_q.size() - oq0), 128'd2);
    check("b2b_pt1", out_q[oq0], ref_decrypt(ct1));
    check("b2b_pt2", out_q[oq0+1], ref_decrypt(ct2));
    check("b2b_no_extra", 128'(acc_q.size() - n0), 128'd2);

    // All-zero block under an all-zero key.
    expand_key('0);
    send('0);
    wait_ov(50);
    check("zero_pt", bus.out_data, ref_decrypt('0));
    tick();

    // Random key and block with random key-store stalls.
    expand_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    ct1 = {$urandom, $urandom, $urandom, $urandom};
    rk_rand = 1'b1;
    send(ct1);
    wait_ov(400);
    check("rand_pt", bus.out_data, ref_decrypt(ct1));
    tick();
    rk_rand = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
